// File: rtl/bus_cycle_pkg.sv
// Shared definitions for the multiplexed address/data peripheral bus masters:
// state encoding, default strobe timing and the idle strobe pattern.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_ADDR_WR    = 3'd2,
    ST_ADDR_HOLD  = 3'd3,
    ST_DATA_SETUP = 3'd4,
    ST_DATA_WR    = 3'd5,
    ST_DATA_HOLD  = 3'd6,
    ST_DONE       = 3'd7
  } wc_state_e;

  localparam int unsigned DEF_T_ADS = 2;
  localparam int unsigned DEF_T_CS  = 4;
  localparam int unsigned DEF_T_ADH = 2;
  localparam int unsigned DEF_T_DS  = 2;
  localparam int unsigned DEF_T_DH  = 2;
  localparam int unsigned DEF_CNT_W = 8;

  // {ad_n, cs_n, rd_n, wr_n} with every strobe released
  localparam logic [3:0] BUS_IDLE = 4'b1111;

endpackage

// File: rtl/wc_timer.sv
// Down-counter for the write-cycle FSM: load sets the count, otherwise it
// decrements to zero and parks there. zero flags the last cycle of a state.
module wc_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/write_cycle.sv
// Bus-master write transaction on the multiplexed AD peripheral bus:
// address setup / strobe / hold, then data setup / strobe / hold, then a
// one-cycle DONE with write_end. All outputs are registered Moore decodes of
// the next state, so they line up exactly with the state register.
// Optional macro WC_B2B_EN: a start seen in DONE launches the next transfer
// directly, without passing through IDLE.
module write_cycle
  import bus_cycle_pkg::*;
#(
  parameter int unsigned T_ADS = DEF_T_ADS,
  parameter int unsigned T_CS  = DEF_T_CS,
  parameter int unsigned T_ADH = DEF_T_ADH,
  parameter int unsigned T_DS  = DEF_T_DS,
  parameter int unsigned T_DH  = DEF_T_DH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_n,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       busy,
  output logic       write_end,
  output logic [2:0] state
);

  // Timer reload for a state of t cycles; a zero-length state still lasts one
  function automatic logic [CNT_W-1:0] tmr_val(input int unsigned t);
    int unsigned eff;
    eff = (t < 1) ? 1 : t;
    return CNT_W'(eff - 1);
  endfunction

  wc_state_e        state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;

  logic [7:0]       ad_out_q, ad_out_d;
  logic             ad_oe_q, ad_oe_d;
  logic [3:0]       strb_q, strb_d;      // {ad_n, cs_n, rd_n, wr_n}
  logic             busy_q, busy_d;
  logic             write_end_q, write_end_d;

  wc_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .zero    (tmr_zero)
  );

  // Next state, operand capture and timer reload on entry to each timed state
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ADDR_SETUP;
          addr_d       = addr;
          data_d       = data;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_ADS);
        end
      end
      ST_ADDR_SETUP: begin
        if (tmr_zero) begin
          state_d      = ST_ADDR_WR;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_CS);
        end
      end
      ST_ADDR_WR: begin
        if (tmr_zero) begin
          state_d      = ST_ADDR_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_ADH);
        end
      end
      ST_ADDR_HOLD: begin
        if (tmr_zero) begin
          state_d      = ST_DATA_SETUP;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_DS);
        end
      end
      ST_DATA_SETUP: begin
        if (tmr_zero) begin
          state_d      = ST_DATA_WR;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_CS);
        end
      end
      ST_DATA_WR: begin
        if (tmr_zero) begin
          state_d      = ST_DATA_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_DH);
        end
      end
      ST_DATA_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef WC_B2B_EN
        if (start) begin
          state_d      = ST_ADDR_SETUP;
          addr_d       = addr;
          data_d       = data;
          tmr_load     = 1'b1;
          tmr_load_val = tmr_val(T_ADS);
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs match state_q
  always_comb begin
    strb_d      = BUS_IDLE;
    ad_oe_d     = 1'b1;
    ad_out_d    = '0;
    busy_d      = (state_d != ST_IDLE);
    write_end_d = (state_d == ST_DONE);
    unique case (state_d)
      ST_ADDR_SETUP: begin strb_d = 4'b0111; ad_out_d = addr_d; end
      ST_ADDR_WR:    begin strb_d = 4'b0010; ad_out_d = addr_d; end
      ST_ADDR_HOLD:  begin strb_d = 4'b0111; ad_out_d = addr_d; end
      ST_DATA_SETUP: begin strb_d = 4'b1111; ad_out_d = data_d; end
      ST_DATA_WR:    begin strb_d = 4'b1010; ad_out_d = data_d; end
      ST_DATA_HOLD:  begin strb_d = 4'b1111; ad_out_d = data_d; end
      default:       begin ad_oe_d = 1'b0; end
    endcase
  end

  // State, operand and output registers; reset releases the bus at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      strb_q      <= BUS_IDLE;
      busy_q      <= 1'b0;
      write_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      strb_q      <= strb_d;
      busy_q      <= busy_d;
      write_end_q <= write_end_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign ad_n      = strb_q[3];
  assign cs_n      = strb_q[2];
  assign rd_n      = strb_q[1];
  assign wr_n      = strb_q[0];
  assign busy      = busy_q;
  assign write_end = write_end_q;
  assign state     = state_q;

endmodule

// File: doc/write_cycle.md
Name: write_cycle

Overview:
Bus-master FSM that performs one write transaction on the multiplexed address/data peripheral bus. It is the counterpart of the existing read-cycle controller on the same bus.
- Address phase: drives the register address on the shared AD lines and strobes it in with AD low, CS low, WR low.
- Data phase: drives the write data and strobes it in with CS low, WR low.
- Sits between the host command sequencer (start, addr, data) and the top-level tristate pad buffer (ad_out, ad_oe).

Parameters:
T_ADS, 2, address setup cycles (AD low, CS/WR high) before the address strobe
T_CS, 4, width in cycles of each CS/WR low strobe (address and data phases)
T_ADH, 2, hold cycles after the address strobe, AD still low
T_DS, 2, data setup cycles before the data strobe
T_DH, 2, data hold cycles after the data strobe
CNT_W, 8, width of the internal down-counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request; sampled only in IDLE (and in DONE when WC_B2B_EN is defined)
addr  input  8  register address; captured at accepted start
data  input  8  write data; captured at accepted start
ad_out  output  8  value to drive on the AD bus
ad_oe  output  1  pad output enable for ad_out
ad_n  output  1  address strobe, active low
cs_n  output  1  chip select, active low
rd_n  output  1  read strobe, active low; held high by this block
wr_n  output  1  write strobe, active low
busy  output  1  high in every state except IDLE
write_end  output  1  one-cycle completion pulse
state  output  3  current state, for debug

Behaviour:
- Reset (async) values:
  - state=IDLE, ad_out=0, ad_oe=0.
  - ad_n=cs_n=rd_n=wr_n=1.
  - busy=0, write_end=0.
  - Captured operands cleared; counter cleared.
- Reset mid-transaction: outputs take the reset values immediately. No partial strobe completes.
- Registered state, Moore outputs. All outputs are decoded from state and the captured operands.
- States, encoding, and outputs (ad_n, cs_n, wr_n, ad_oe, ad_out, busy):
  - IDLE=0: 1, 1, 1, 0, 0, busy=0.
  - ADDR_SETUP=1: 0, 1, 1, 1, addr_q.
  - ADDR_WR=2: 0, 0, 0, 1, addr_q.
  - ADDR_HOLD=3: 0, 1, 1, 1, addr_q.
  - DATA_SETUP=4: 1, 1, 1, 1, data_q.
  - DATA_WR=5: 1, 0, 0, 1, data_q.
  - DATA_HOLD=6: 1, 1, 1, 1, data_q.
  - DONE=7: 1, 1, 1, 0, 0, write_end=1.
  - rd_n=1 in all states. busy=1 in states 1-7.
- Transitions:
  - IDLE -> ADDR_SETUP on start=1; capture addr_q and data_q on the same edge.
  - Each timed state (1-6) lasts exactly its parameter count in cycles. ADDR_WR and DATA_WR use T_CS.
  - Timed states advance sequentially 1 -> 2 -> 3 -> 4 -> 5 -> 6 -> 7.
  - DONE -> IDLE after 1 cycle.
- Timer: down-counter, loaded with T_x-1 on entry to each timed state. The state exits on the edge where counter==0.
- Parameter value 0 is treated as 1. Values above 2^CNT_W-1 are a configuration error.
- Latency: start sampled at edge k; write_end is high in cycle k+1+T_ADS+2*T_CS+T_ADH+T_DS+T_DH. With defaults this is k+17.
- start while busy (other than DONE with B2B): ignored. No queueing.
- addr/data changing after acceptance has no effect on the bus.

Optional Feature:
WC_B2B_EN
- Defined: in DONE, start=1 goes directly to ADDR_SETUP and captures new operands, skipping IDLE. write_end still pulses for the finished transfer. busy stays high continuously.
- Undefined: DONE always returns to IDLE. start in DONE is ignored.

Decomposition:
- Package bus_cycle_pkg holds:
  - the 3-bit state encoding constants;
  - default timing values;
  - the idle bus output constant {ad_n,cs_n,rd_n,wr_n}=4'b1111.
- Sub-module wc_timer (inputs: load, load value, clk, rst; output: zero flag) with parameter CNT_W. It is the only natural split.

Test Plan:
- Reset then idle: rst pulse, start=0 for 20 cycles -> all strobes 1, ad_oe=0, busy=0, state=0 throughout.
- Single write, defaults: start with addr=8'h2A, data=8'h5C at edge k ->
  - ad_n low for 8 cycles;
  - cs_n/wr_n low for cycles k+3..k+6 with ad_out=8'h2A;
  - cs_n/wr_n low for cycles k+11..k+14 with ad_out=8'h5C;
  - write_end high only at k+17.
- Ignored start: second start with addr=8'hFF asserted at k+5 -> bus shows 8'h2A then 8'h5C; no second transfer.
- Async reset mid-cycle: assert rst during DATA_WR -> cs_n, wr_n, ad_oe return to 1/1/0 before the next clk edge; no write_end.
- Parameter edge: T_CS=0, T_ADS=1 -> strobes are exactly 1 cycle wide; latency matches the formula with 0 treated as 1.
- WC_B2B_EN: start in DONE with addr=8'h10 -> write_end pulses, next cycle state=ADDR_SETUP with ad_out=8'h10, busy never drops.
